dnn_seq_mac: RTL

Parametrised, time-multiplexed two-layer fully-connected network engine: N_IN inputs, N_HID hidden neurons, N_OUT outputs, signed weights. It generalises the fixed 4-4-2 combinational network to arbitrary layer sizes. Fully parallel multipliers are replaced by a single shared multiply-accumulate unit sequenced by an FSM, with valid/ready handshakes on both sides. It sits between the input sample source and the output consumer at the network top level.

---
 rtl/dnn_pkg.sv | 39 +++
 rtl/dnn_mac.sv | 56 +++++
 rtl/dnn_seq_mac.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dnn_pkg.sv
// dnn_pkg: shared types and helpers for the sequential two-layer MAC engine.
// Holds the FSM state encoding, the signed saturation helper and the
// accumulator sizing function used by dnn_seq_mac and dnn_mac.
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L2   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Widest product plus enough growth bits for the longest dot product,
  // with one guard bit so the running sum can never wrap.
  function automatic int acc_width(input int in_w, input int w_w, input int hid_w,
                                   input int n_in, input int n_hid);
    return max2(in_w + w_w, hid_w + w_w) + $clog2(max2(n_in, n_hid)) + 1;
  endfunction

  // Clamp a signed value to the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/dnn_mac.sv
// dnn_mac: single shared signed multiply-accumulate unit.
// Each enabled cycle adds a*b to the accumulator; on 'last' the saturated
// value of (acc + a*b) is presented for write-back and the accumulator clears.
module dnn_mac
  import dnn_pkg::*;
#(
  parameter int A_W   = 12,
  parameter int B_W   = 5,
  parameter int ACC_W = 20,
  parameter int HID_W = 12,
  parameter int OUT_W = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic                    en,
  input  logic                    last,
  input  logic                    clr,
  output logic signed [HID_W-1:0] hid_wb,
  output logic signed [OUT_W-1:0] out_wb
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] sum;

  // Multiply, add and saturate in one combinational path; next accumulator value.
  always_comb begin
    a_ext  = ACC_W'(a);
    b_ext  = ACC_W'(b);
    prod   = a_ext * b_ext;
    sum    = acc_q + prod;
    hid_wb = HID_W'(saturate(64'(sum), HID_W));
    out_wb = OUT_W'(saturate(64'(sum), OUT_W));
    acc_d  = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = last ? '0 : sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dnn_seq_mac.sv
// dnn_seq_mac: time-multiplexed N_IN-N_HID-N_OUT fully-connected network.
// One shared MAC walks layer 1 then layer 2 under an IDLE/L1/L2/DONE FSM,
// with valid/ready handshakes on input and output.
// Build option: define DNN_RELU_EN to rectify hidden activations.
module dnn_seq_mac
  import dnn_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int IN_W  = 5,
  parameter int W_W   = 5,
  parameter int HID_W = 12,
  parameter int OUT_W = 17
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_IN*IN_W-1:0]         x,
  input  logic [N_IN*N_HID*W_W-1:0]    w_ih,
  input  logic [N_HID*N_OUT*W_W-1:0]   w_ho,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N_OUT*OUT_W-1:0]       out,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int A_W   = max2(IN_W, HID_W);
  localparam int ACC_W = acc_width(IN_W, W_W, HID_W, N_IN, N_HID);
  localparam int CNT_W = $clog2(max2(max2(N_IN, N_HID), N_OUT)) + 1;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             i_q, i_d, j_q, j_d, k_q, k_d;
  logic [N_IN*IN_W-1:0]         x_q, x_d;
  logic [N_IN*N_HID*W_W-1:0]    w_ih_q, w_ih_d;
  logic [N_HID*N_OUT*W_W-1:0]   w_ho_q, w_ho_d;
  logic signed [HID_W-1:0]      hid_q [N_HID];
  logic signed [HID_W-1:0]      hid_d [N_HID];
  logic signed [OUT_W-1:0]      out_q [N_OUT];
  logic signed [OUT_W-1:0]      out_d [N_OUT];
  logic                         out_valid_q, out_valid_d;
  logic                         in_ready_q, in_ready_d;

  logic signed [IN_W-1:0]       x_sel;
  logic signed [W_W-1:0]        wih_sel;
  logic signed [W_W-1:0]        who_sel;
  logic signed [HID_W-1:0]      hid_sel;
  logic signed [A_W-1:0]        a_op;
  logic signed [W_W-1:0]        b_op;
  logic                         mac_en, mac_last, mac_clr;
  logic signed [HID_W-1:0]      hid_wb, hid_val;
  logic signed [OUT_W-1:0]      out_wb;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
    assign out[gi*OUT_W +: OUT_W] = out_q[gi];
  end

  dnn_mac #(
    .A_W   (A_W),
    .B_W   (W_W),
    .ACC_W (ACC_W),
    .HID_W (HID_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a_op),
    .b      (b_op),
    .en     (mac_en),
    .last   (mac_last),
    .clr    (mac_clr),
    .hid_wb (hid_wb),
    .out_wb (out_wb)
  );

  // Operand select: pick the sample/hidden value and weight for the current counters.
  always_comb begin
    x_sel   = '0;
    wih_sel = '0;
    hid_sel = '0;
    who_sel = '0;
    for (int n = 0; n < N_IN; n++) begin
      if (i_q == CNT_W'(n)) x_sel = x_q[n*IN_W +: IN_W];
    end
    for (int jn = 0; jn < N_HID; jn++) begin
      for (int in = 0; in < N_IN; in++) begin
        if (j_q == CNT_W'(jn) && i_q == CNT_W'(in))
          wih_sel = w_ih_q[(jn*N_IN + in)*W_W +: W_W];
      end
    end
    for (int n = 0; n < N_HID; n++) begin
      if (j_q == CNT_W'(n)) hid_sel = hid_q[n];
    end
    for (int kn = 0; kn < N_OUT; kn++) begin
      for (int jn = 0; jn < N_HID; jn++) begin
        if (k_q == CNT_W'(kn) && j_q == CNT_W'(jn))
          who_sel = w_ho_q[(kn*N_HID + jn)*W_W +: W_W];
      end
    end
    if (state_q == L2) begin
      a_op = A_W'(hid_sel);
      b_op = who_sel;
    end else begin
      a_op = A_W'(x_sel);
      b_op = wih_sel;
    end
  end

  // Hidden write-back value, optionally rectified.
  always_comb begin
`ifdef DNN_RELU_EN
    hid_val = hid_wb[HID_W-1] ? '0 : hid_wb;
`else
    hid_val = hid_wb;
`endif
  end

  // FSM next state, counter sequencing and result array updates.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    x_d         = x_q;
    w_ih_d      = w_ih_q;
    w_ho_d      = w_ho_q;
    hid_d       = hid_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    mac_en      = 1'b0;
    mac_last    = 1'b0;
    mac_clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = x;
          w_ih_d     = w_ih;
          w_ho_d     = w_ho;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          mac_clr    = 1'b1;
          in_ready_d = 1'b0;
          state_d    = L1;
        end
      end
      L1: begin
        mac_en = 1'b1;
        if (i_q == CNT_W'(N_IN - 1)) begin
          mac_last = 1'b1;
          i_d      = '0;
          for (int n = 0; n < N_HID; n++) begin
            if (j_q == CNT_W'(n)) hid_d[n] = hid_val;
          end
          if (j_q == CNT_W'(N_HID - 1)) begin
            j_d     = '0;
            k_d     = '0;
            state_d = L2;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      L2: begin
        mac_en = 1'b1;
        if (j_q == CNT_W'(N_HID - 1)) begin
          mac_last = 1'b1;
          j_d      = '0;
          for (int n = 0; n < N_OUT; n++) begin
            if (k_q == CNT_W'(n)) out_d[n] = out_wb;
          end
          if (k_q == CNT_W'(N_OUT - 1)) begin
            k_d         = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset discards any partial computation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      x_q         <= '0;
      w_ih_q      <= '0;
      w_ho_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      for (int n = 0; n < N_HID; n++) hid_q[n] <= '0;
      for (int n = 0; n < N_OUT; n++) out_q[n] <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      x_q         <= x_d;
      w_ih_q      <= w_ih_d;
      w_ho_q      <= w_ho_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      hid_q       <= hid_d;
      out_q       <= out_d;
    end
  end

endmodule
